// File: rtl/fft_pkg.sv
// Shared constants, state encoding and bit-reversal helper for the FFT sequencer.
package fft_pkg;

    localparam int FFT_N_LOG2  = 7;
    localparam int FFT_TW_BITS = 6;

    localparam logic [5:0] ST_IDLE  = 6'b000001;
    localparam logic [5:0] ST_LOAD  = 6'b000010;
    localparam logic [5:0] ST_CALC  = 6'b000100;
    localparam logic [5:0] ST_DRAIN = 6'b001000;
    localparam logic [5:0] ST_OUT   = 6'b010000;
    localparam logic [5:0] ST_DONE  = 6'b100000;

    typedef enum logic [5:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_CALC  = ST_CALC,
        S_DRAIN = ST_DRAIN,
        S_OUT   = ST_OUT,
        S_DONE  = ST_DONE
    } fft_state_e;

    function automatic logic [FFT_N_LOG2-1:0] bitrev7(input logic [FFT_N_LOG2-1:0] v);
        logic [FFT_N_LOG2-1:0] r;
        for (int i = 0; i < FFT_N_LOG2; i++) begin
            r[i] = v[FFT_N_LOG2-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Fixed-depth delay line aligning butterfly write-back controls with the datapath latency.
module fft_wb_delay
    import fft_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = FFT_N_LOG2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_addr_a,
    input  logic [AW-1:0] i_addr_b,
    input  logic          i_scale,
    output logic          o_wr_en,
    output logic [AW-1:0] o_addr_a,
    output logic [AW-1:0] o_addr_b,
    output logic          o_scale
);

    localparam int W = 2 * AW + 2;

    logic [W-1:0] r_pipe [DEPTH];
    logic [W-1:0] w_in;

    assign w_in = {i_rd_en, i_addr_a, i_addr_b, i_scale};

    // Shift stage; reset drops any write-back still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign {o_wr_en, o_addr_a, o_addr_b, o_scale} = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_seq.sv
// Address/control sequencer for the in-place 128-point radix-2 DIT FFT.
// Build macro FFT_SCALE_EN enables the per-stage divide-by-2 flag on bf_scale.
module fft_seq
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int BF_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fft_go,
    input  logic                   ld_valid,
    output logic                   ld_wren,
    output logic [N_LOG2-1:0]      ld_addr,
    output logic                   bf_rd_en,
    output logic [N_LOG2-1:0]      bf_addr_a,
    output logic [N_LOG2-1:0]      bf_addr_b,
    output logic [FFT_TW_BITS-1:0] tw_idx,
    output logic                   bf_wr_en,
    output logic [N_LOG2-1:0]      bf_wr_addr_a,
    output logic [N_LOG2-1:0]      bf_wr_addr_b,
    output logic                   bf_scale,
    output logic                   out_rd_en,
    output logic [N_LOG2-1:0]      out_addr,
    output logic                   out_valid,
    output logic                   fft_busy,
    output logic                   fft_done
);

    localparam int AW = N_LOG2;
    localparam int JW = N_LOG2 - 1;
    localparam int SW = $clog2(N_LOG2);
    localparam int DW = $clog2(BF_LAT + 2);

    localparam logic [AW-1:0] ADDR_LAST  = {AW{1'b1}};
    localparam logic [JW-1:0] BF_LAST    = {JW{1'b1}};
    localparam logic [SW-1:0] STAGE_LAST = SW'(N_LOG2 - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(BF_LAT);

    fft_state_e    r_state;
    logic [AW-1:0] r_ld_cnt;
    logic [SW-1:0] r_stage;
    logic [JW-1:0] r_bf_j;
    logic [DW-1:0] r_drain_cnt;
    logic [AW-1:0] r_out_cnt;
    logic          r_out_valid;

    logic          w_is_load;
    logic          w_is_calc;
    logic          w_is_out;
    logic [AW-1:0] w_half;
    logic [JW-1:0] w_pos;
    logic [AW-1:0] w_grp;
    logic [AW-1:0] w_addr_a;
    logic [AW-1:0] w_addr_b;
    logic [JW-1:0] w_tw;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr_a;
    logic [AW-1:0] w_rd_addr_b;
    logic [JW-1:0] w_rd_tw;
    logic          w_scale;

    // Sequencing FSM and its counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ld_cnt    <= '0;
            r_stage     <= '0;
            r_bf_j      <= '0;
            r_drain_cnt <= '0;
            r_out_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ld_cnt    <= '0;
                    r_stage     <= '0;
                    r_bf_j      <= '0;
                    r_drain_cnt <= '0;
                    r_out_cnt   <= '0;
                    if (fft_go) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        r_ld_cnt <= r_ld_cnt + AW'(1);
                        if (r_ld_cnt == ADDR_LAST) begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_bf_j <= r_bf_j + JW'(1);
                    if (r_bf_j == BF_LAST) begin
                        r_drain_cnt <= '0;
                        r_state     <= S_DRAIN;
                    end
                end
                // Wait out the butterfly pipeline so the next stage never reads stale data.
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + DW'(1);
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_drain_cnt <= '0;
                        if (r_stage == STAGE_LAST) begin
                            r_state <= S_OUT;
                        end else begin
                            r_stage <= r_stage + SW'(1);
                            r_bf_j  <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_OUT: begin
                    r_out_cnt <= r_out_cnt + AW'(1);
                    if (r_out_cnt == ADDR_LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Readout data appears one cycle after its RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (r_state == S_OUT);
        end
    end

    assign w_is_load = (r_state == S_LOAD);
    assign w_is_calc = (r_state == S_CALC);
    assign w_is_out  = (r_state == S_OUT);

    // Butterfly j of stage s: insert a zero bit at position s of j to get the upper operand.
    assign w_half   = AW'(1) << r_stage;
    assign w_pos    = r_bf_j & (w_half[JW-1:0] - JW'(1));
    assign w_grp    = {1'b0, r_bf_j} >> r_stage;
    assign w_addr_a = (w_grp << (r_stage + SW'(1))) | {1'b0, w_pos};
    assign w_addr_b = w_addr_a + w_half;
    assign w_tw     = w_pos << (SW'(JW) - r_stage);

    // Operand addresses are forced to zero outside CALC.
    always_comb begin
        w_rd_en     = 1'b0;
        w_rd_addr_a = '0;
        w_rd_addr_b = '0;
        w_rd_tw     = '0;
        if (w_is_calc) begin
            w_rd_en     = 1'b1;
            w_rd_addr_a = w_addr_a;
            w_rd_addr_b = w_addr_b;
            w_rd_tw     = w_tw;
        end else begin
            w_rd_en     = 1'b0;
        end
    end

`ifdef FFT_SCALE_EN
    assign w_scale = w_rd_en;
`else
    assign w_scale = 1'b0;
`endif

    fft_wb_delay #(
        .DEPTH (BF_LAT),
        .AW    (AW)
    ) u_wb_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_rd_en  (w_rd_en),
        .i_addr_a (w_rd_addr_a),
        .i_addr_b (w_rd_addr_b),
        .i_scale  (w_scale),
        .o_wr_en  (bf_wr_en),
        .o_addr_a (bf_wr_addr_a),
        .o_addr_b (bf_wr_addr_b),
        .o_scale  (bf_scale)
    );

    assign bf_rd_en  = w_rd_en;
    assign bf_addr_a = w_rd_addr_a;
    assign bf_addr_b = w_rd_addr_b;
    assign tw_idx    = FFT_TW_BITS'(w_rd_tw);

    assign ld_wren   = w_is_load & ld_valid;
    assign ld_addr   = w_is_load ? bitrev7(r_ld_cnt) : '0;

    assign out_rd_en = w_is_out;
    assign out_addr  = w_is_out ? r_out_cnt : '0;
    assign out_valid = r_out_valid;

    assign fft_busy  = (r_state != S_IDLE);
    assign fft_done  = (r_state == S_DONE);

endmodule
